mem_copy_engine: RTL and testbench



---
 rtl/mem_copy_engine_pkg.sv | 25 ++
 rtl/mem_copy_range_check.sv | 43 ++++
 rtl/mem_copy_engine.sv | 190 +++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_pkg
// Shared definitions for the memory copy engine: the state encodings of the
// copy FSM (3-bit values, also visible on the debug state output) and the
// default size of the target data memory used by the range checks.
// -----------------------------------------------------------------------------
package mem_copy_engine_pkg;

   localparam int MEM_BYTES_DEF = 256;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CHECK  = 3'd1;
   localparam logic [2:0] ST_READ   = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_CHECK  = ST_CHECK,
      S_READ   = ST_READ,
      S_WRITE  = ST_WRITE,
      S_FINISH = ST_FINISH
   } state_e;

endpackage

// File: rtl/mem_copy_range_check.sv
// -----------------------------------------------------------------------------
// mem_copy_range_check
// Combinational legality check of a copy command.
//   src, dst      : byte addresses of the source / destination blocks
//   len           : number of 32-bit words
//   misaligned    : either address is not word aligned
//   out_of_range  : either block runs past the end of the memory
//   overlap       : destination starts strictly inside the source block, so an
//                   ascending copy would overwrite source words before reading
// End addresses are formed at 33 bits so a block that wraps past 2^32 cannot
// appear to be in range.
// -----------------------------------------------------------------------------
module mem_copy_range_check
   import mem_copy_engine_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int LEN_W     = 8
) (
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   output logic             misaligned,
   output logic             out_of_range,
   output logic             overlap
);

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   logic [32:0] span;
   logic [32:0] src_end;
   logic [32:0] dst_end;

   always_comb begin
      span    = {{(31-LEN_W){1'b0}}, len, 2'b00};
      src_end = {1'b0, src} + span;
      dst_end = {1'b0, dst} + span;

      misaligned   = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
      out_of_range = (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);
      overlap      = (dst > src) && ({1'b0, dst} < src_end);
   end

endmodule

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Bus initiator that copies len 32-bit words from src_addr to dst_addr in
// ascending order through a combinational-read data memory.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : one-cycle command strobe, accepted only when idle
//   src_addr, dst_addr  : byte addresses, sampled with an accepted start
//   len                 : word count, sampled with an accepted start
//   abort               : ends the transfer at the next edge
//   busy, done, err     : status; done is a one-cycle pulse, err is held
//                         until the next accepted start
//   words_done          : words written by the current / last command
//   mem_*               : memory-side bus (all registered)
//   state_dbg           : current FSM state encoding
//
// Handshake: start is a single-cycle strobe with no ready; it takes effect
// only on an edge where the engine is idle, otherwise it is dropped. done
// pulses for exactly one cycle when a command ends for any reason.
//
// Every memory-side output is a flop loaded from the next-state values, so
// address and write data are stable for the whole cycle mem_write is high.
// -----------------------------------------------------------------------------
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int LEN_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic [31:0]      mem_address,
   output logic [31:0]      mem_write_data,
   output logic             mem_read,
   input  logic [31:0]      mem_read_data,
   output logic             mem_write,
   output logic [2:0]       state_dbg
);

   state_e           state_q, state_d;
   logic [31:0]      src_ptr_q, src_ptr_d;
   logic [31:0]      dst_ptr_q, dst_ptr_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [LEN_W-1:0] words_done_q, words_done_d;
   logic             err_q, err_d;
   logic [31:0]      data_buf_q, data_buf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [31:0]      mem_address_q, mem_address_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;

   logic misaligned, out_of_range, overlap;

   // The latched command registers hold the sampled command while in CHECK.
   mem_copy_range_check #(
      .MEM_BYTES(MEM_BYTES),
      .LEN_W    (LEN_W)
   ) u_range_check (
      .src         (src_ptr_q),
      .dst         (dst_ptr_q),
      .len         (remaining_q),
      .misaligned  (misaligned),
      .out_of_range(out_of_range),
      .overlap     (overlap)
   );

   always_comb begin
      state_d      = state_q;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      remaining_d  = remaining_q;
      words_done_d = words_done_q;
      err_d        = err_q;
      data_buf_d   = data_buf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_ptr_d    = src_addr;
               dst_ptr_d    = dst_addr;
               remaining_d  = len;
               words_done_d = '0;
               err_d        = 1'b0;
               state_d      = S_CHECK;
            end
         end
         S_CHECK: begin
            // abort outranks a rejected command, so err stays low on abort
            if (abort) begin
               state_d = S_FINISH;
            end else if (misaligned || out_of_range || overlap) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else if (remaining_q == '0) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (abort) begin
               state_d = S_FINISH;
            end else begin
               data_buf_d = mem_read_data;
               src_ptr_d  = src_ptr_q + 32'd4;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            // the write has landed this cycle, so it is counted even on abort
            dst_ptr_d    = dst_ptr_q + 32'd4;
            words_done_d = words_done_q + LEN_W'(1);
            remaining_d  = remaining_q - LEN_W'(1);
            if (abort || (remaining_q == LEN_W'(1))) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_READ;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_FINISH);
      mem_read_d    = (state_d == S_READ);
      mem_write_d   = (state_d == S_WRITE);
      mem_address_d = '0;
      mem_wdata_d   = '0;
      if (state_d == S_READ) begin
         mem_address_d = src_ptr_d;
      end else if (state_d == S_WRITE) begin
         mem_address_d = dst_ptr_d;
         mem_wdata_d   = data_buf_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         src_ptr_q     <= '0;
         dst_ptr_q     <= '0;
         remaining_q   <= '0;
         words_done_q  <= '0;
         err_q         <= 1'b0;
         data_buf_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         src_ptr_q     <= src_ptr_d;
         dst_ptr_q     <= dst_ptr_d;
         remaining_q   <= remaining_d;
         words_done_q  <= words_done_d;
         err_q         <= err_d;
         data_buf_q    <= data_buf_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign words_done     = words_done_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_wdata_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Directed and randomized commands against a byte-array data memory. A word
// level reference image (ref_w) and an expected bus-transaction queue are
// built from the copy rules for each command and compared with the DUT bus
// activity, status outputs and final memory contents.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;
   import mem_copy_engine_pkg::*;

   localparam int LEN_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [LEN_W-1:0] len = '0;
   logic             busy, done, err;
   logic [LEN_W-1:0] words_done;
   logic [31:0]      mem_address, mem_write_data, mem_read_data;
   logic             mem_read, mem_write;
   logic [2:0]       state_dbg;

   mem_copy_engine #(.MEM_BYTES(256), .LEN_W(LEN_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .len           (len),
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .words_done    (words_done),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read      (mem_read),
      .mem_read_data (mem_read_data),
      .mem_write     (mem_write),
      .state_dbg     (state_dbg)
   );

   // ---------------- data memory (little-endian bytes) ----------------
   logic [7:0]  mem [256];
   logic        init_we = 1'b0;
   logic [5:0]  init_idx = '0;
   logic [31:0] init_data = '0;

   always @(posedge clk) begin
      if (init_we) begin
         mem[{init_idx, 2'b00}] <= init_data[7:0];
         mem[{init_idx, 2'b01}] <= init_data[15:8];
         mem[{init_idx, 2'b10}] <= init_data[23:16];
         mem[{init_idx, 2'b11}] <= init_data[31:24];
      end else if (mem_write) begin
         mem[{mem_address[7:2], 2'b00}] <= mem_write_data[7:0];
         mem[{mem_address[7:2], 2'b01}] <= mem_write_data[15:8];
         mem[{mem_address[7:2], 2'b10}] <= mem_write_data[23:16];
         mem[{mem_address[7:2], 2'b11}] <= mem_write_data[31:24];
      end
   end

   always_comb begin
      mem_read_data = {mem[{mem_address[7:2], 2'b11}], mem[{mem_address[7:2], 2'b10}],
                       mem[{mem_address[7:2], 2'b01}], mem[{mem_address[7:2], 2'b00}]};
   end

   // ---------------- scoreboard ----------------
   int          vectors = 0;
   int          miscompares = 0;
   logic [64:0] exp_q[$];      // {is_write, address, write data}
   logic [31:0] ref_w [64];    // reference memory image, one entry per word

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input int w);
      return {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
   endfunction

   task automatic compare_mem();
      for (int w = 0; w < 64; w++) chk($sformatf("mem_w%0d", w), mem_word(w), ref_w[w]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_word(input int w, input logic [31:0] d);
      @(negedge clk);
      init_we   = 1'b1;
      init_idx  = w[5:0];
      init_data = d;
      @(posedge clk);
      #1 init_we = 1'b0;
      ref_w[w] = d;
   endtask

   // abort_w: index of the write during which abort is raised (-1 = none)
   task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int abort_w, input bit abort_with_start);
      bit          model_err;
      int          exp_words, exp_cyc, cyc, writes;
      bit          finished;
      longint      ls, ld, span;
      logic [64:0] e;
      logic [31:0] word;

      ls = longint'(s);
      ld = longint'(d);
      span = 4 * longint'(n);
      model_err = (ls % 4 != 0) || (ld % 4 != 0) || (ls + span > 256) || (ld + span > 256) ||
                  ((ld > ls) && (ld < ls + span));
      exp_q.delete();
      if (model_err) begin
         exp_words = 0;
         exp_cyc   = 2;
      end else begin
         exp_words = (abort_w >= 0 && abort_w < n) ? abort_w + 1 : n;
         exp_cyc   = 2 * exp_words + 2;
         for (int i = 0; i < exp_words; i++) begin
            word = ref_w[int'(ls / 4) + i];
            exp_q.push_back({1'b0, s + 32'(4 * i), 32'h0});
            exp_q.push_back({1'b1, d + 32'(4 * i), word});
            ref_w[int'(ld / 4) + i] = word;
         end
      end

      @(negedge clk);
      start    = 1'b1;
      src_addr = s;
      dst_addr = d;
      len      = n[LEN_W-1:0];
      abort    = abort_with_start;
      @(posedge clk);
      cyc = 0;
      writes = 0;
      finished = 1'b0;
      while (!finished && cyc < 200) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         cyc++;
         if (cyc == 1) begin
            chk("busy_first", busy, 1);
            chk("err_cleared", err, 0);
            chk("wd_cleared", words_done, 0);
         end
         if (cyc == 3) begin
            // a start while busy must be ignored
            start    = 1'b1;
            src_addr = $urandom;
            dst_addr = $urandom;
            len      = LEN_W'($urandom);
         end
         chk("rw_exclusive", mem_read & mem_write, 0);
         if (mem_read || mem_write) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_access", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("access_kind", mem_write, e[64]);
               chk("access_addr", mem_address, e[63:32]);
               if (mem_write) begin
                  chk("write_data", mem_write_data, e[31:0]);
                  if (writes == abort_w) abort = 1'b1;
                  writes++;
               end
            end
         end else begin
            chk("idle_addr", mem_address, 0);
            chk("idle_wdata", mem_write_data, 0);
         end
         if (done) begin
            finished = 1'b1;
            chk("done_cycle", cyc, exp_cyc);
            chk("words_done", words_done, exp_words);
            chk("err", err, model_err);
            chk("busy_at_done", busy, 1);
         end else begin
            chk("busy", busy, 1);
         end
      end
      start = 1'b0;
      if (!finished) chk("done_timeout", 0, 1);
      chk("exp_q_empty", exp_q.size(), 0);
      @(negedge clk);
      abort = 1'b0;
      chk("busy_after", busy, 0);
      chk("done_pulse", done, 0);
      chk("err_hold", err, model_err);
      chk("wd_hold", words_done, exp_words);
      compare_mem();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rs, rd;
      int          rn, ra;
      bit          saw_write;

      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wd", words_done, 0);
      chk("rst_read", mem_read, 0);
      chk("rst_write", mem_write, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_wdata", mem_write_data, 0);
      chk("rst_state", state_dbg, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      load_word(0, 32'h11111111);
      load_word(1, 32'h22222222);
      load_word(2, 32'h33333333);
      load_word(3, 32'h44444444);
      for (int w = 4; w < 64; w++) load_word(w, $urandom);

      run_cmd(32'h00, 32'h80, 4, -1, 1'b0);   // basic copy
      run_cmd(32'h02, 32'h40, 1, -1, 1'b0);   // misaligned source
      run_cmd(32'h00, 32'hF8, 3, -1, 1'b0);   // destination past end
      run_cmd(32'h20, 32'h30, 0, -1, 1'b0);   // empty copy
      run_cmd(32'h10, 32'h14, 2, -1, 1'b0);   // forward overlap rejected
      run_cmd(32'h14, 32'h10, 2, -1, 1'b0);   // reverse overlap allowed
      run_cmd(32'h40, 32'h60, 4, 1, 1'b0);    // abort in second write
      run_cmd(32'h50, 32'hA0, 2, -1, 1'b1);   // start wins over abort
      run_cmd(32'hFC, 32'h00, 1, -1, 1'b0);   // last word of memory
      run_cmd(32'hFFFFFFF0, 32'h00, 8, -1, 1'b0); // wraps at 32 bits

      // reset during a write
      @(negedge clk);
      start    = 1'b1;
      src_addr = 32'h00;
      dst_addr = 32'hC0;
      len      = 4;
      @(posedge clk);
      saw_write = 1'b0;
      for (int i = 0; i < 20 && !saw_write; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_write) saw_write = 1'b1;
      end
      start = 1'b0;
      chk("saw_write_before_reset", saw_write, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_write", mem_write, 0);
      chk("arst_read", mem_read, 0);
      chk("arst_addr", mem_address, 0);
      chk("arst_wdata", mem_write_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_wd", words_done, 0);
      chk("arst_state", state_dbg, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      run_cmd(32'h00, 32'hC0, 4, -1, 1'b0);

      // randomized commands
      for (int k = 0; k < 12; k++) begin
         rs = 32'($urandom_range(0, 63) * 4);
         rd = 32'($urandom_range(0, 63) * 4);
         if ($urandom_range(0, 5) == 0) rs = rs | 32'($urandom_range(1, 3));
         rn = $urandom_range(0, 12);
         ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
         run_cmd(rs, rd, rn, ra, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
